// File: rtl/timer_pkg.sv
// Shared definitions for the reload timer: register offsets, TCON layout, address decode.
// The PSC register decodes only when TIMER_PRESCALE_EN is defined.
package timer_pkg;

    localparam logic [31:0] OFF_TH   = 32'h0;
    localparam logic [31:0] OFF_TL   = 32'h4;
    localparam logic [31:0] OFF_TCON = 32'h8;
    localparam logic [31:0] OFF_PSC  = 32'hC;

    localparam int unsigned TCON_EN = 0;
    localparam int unsigned TCON_IE = 1;
    localparam int unsigned TCON_IF = 2;
    localparam int unsigned TCON_OS = 3;

    localparam logic [31:0] TCON_MASK = 32'hF;

    // Field order mirrors the TCON bit indices (os is bit 3, en is bit 0).
    typedef struct packed {
        logic os;
        logic flag;
        logic ie;
        logic en;
    } tcon_t;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_TH,
        SEL_TL,
        SEL_TCON,
        SEL_PSC
    } reg_sel_e;

    function automatic reg_sel_e decode_addr(input logic [31:0] addr, input logic [31:0] base);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (addr == base + OFF_TH)        sel = SEL_TH;
        else if (addr == base + OFF_TL)   sel = SEL_TL;
        else if (addr == base + OFF_TCON) sel = SEL_TCON;
`ifdef TIMER_PRESCALE_EN
        else if (addr == base + OFF_PSC)  sel = SEL_PSC;
`endif
        return sel;
    endfunction

endpackage

// File: rtl/timer_if.sv
// CPU-side register bus of the timer: strobes, address, data and the level interrupt.
interface timer_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output rd, output wr, output addr, output wdata, input rdata, input irq);
    modport slave  (input rd, input wr, input addr, input wdata, output rdata, output irq);
endinterface

// File: rtl/timer_prescaler.sv
// Tick divider for the timer: one tick every psc+1 enabled cycles.
// Compiled only when TIMER_PRESCALE_EN is defined.
`ifdef TIMER_PRESCALE_EN
module timer_prescaler #(
    parameter int unsigned PSC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [PSC_W-1:0] psc,
    output logic             tick
);

    logic [PSC_W-1:0] cnt;

    // A PSC write restarts the period, so it also swallows a tick due that cycle.
    assign tick = en && !clr && (cnt == psc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!en || clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PSC_W'(1);
        end
    end

endmodule
`endif

// File: rtl/timer_unit.sv
// Memory-mapped 32-bit reload timer: TL counts up and reloads from TH on overflow, irq = IE & IF.
// Define TIMER_PRESCALE_EN to add the PSC register and tick prescaler at BASE_ADDR+C.
module timer_unit
    import timer_pkg::*;
#(
`ifdef TIMER_PRESCALE_EN
    parameter int unsigned PSC_W     = 16,
`endif
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic    clk,
    input  logic    reset,
    timer_if.slave  bus
);

    reg_sel_e    sel;
    logic        wr_th;
    logic        wr_tl;
    logic        wr_tcon;
    logic [31:0] th;
    logic [31:0] tl;
    tcon_t       tcon;
    logic        tick;
    logic        ovf;

    assign sel     = decode_addr(bus.addr, BASE_ADDR);
    assign wr_th   = bus.wr && (sel == SEL_TH);
    assign wr_tl   = bus.wr && (sel == SEL_TL);
    assign wr_tcon = bus.wr && (sel == SEL_TCON);

`ifdef TIMER_PRESCALE_EN
    logic [PSC_W-1:0] psc;
    logic             wr_psc;

    assign wr_psc = bus.wr && (sel == SEL_PSC);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc <= '0;
        end else if (wr_psc) begin
            psc <= bus.wdata[PSC_W-1:0];
        end
    end

    timer_prescaler #(.PSC_W(PSC_W)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (tcon.en),
        .clr   (wr_psc),
        .psc   (psc),
        .tick  (tick)
    );
`else
    assign tick = tcon.en;
`endif

    assign ovf = tick && (tl == 32'hFFFF_FFFF);

    // NOTE: non-blocking assignments make every right-hand side the pre-edge value, which is
    // exactly why a TH write coinciding with an overflow reloads the old TH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
        end else begin
            if (wr_th) th <= bus.wdata;

            if (wr_tl)     tl <= bus.wdata;
            else if (tick) tl <= ovf ? th : tl + 32'd1;

            // Software's EN wins over the one-shot auto-clear.
            if (wr_tcon) begin
                tcon.en <= bus.wdata[TCON_EN];
                tcon.ie <= bus.wdata[TCON_IE];
                tcon.os <= bus.wdata[TCON_OS];
            end else if (ovf && tcon.os) begin
                tcon.en <= 1'b0;
            end

            // A new overflow beats a write-1-clear so no event is lost.
            if (ovf)                                tcon.flag <= 1'b1;
            else if (wr_tcon && bus.wdata[TCON_IF]) tcon.flag <= 1'b0;
        end
    end

    // NOTE: the default assignment first covers every path through always_comb, so no latch.
    always_comb begin
        bus.rdata = '0;
        if (bus.rd) begin
            unique case (sel)
                SEL_TH:   bus.rdata = th;
                SEL_TL:   bus.rdata = tl;
                SEL_TCON: bus.rdata = {28'd0, tcon} & TCON_MASK;
`ifdef TIMER_PRESCALE_EN
                SEL_PSC:  bus.rdata = 32'(psc);
`endif
                default:  bus.rdata = '0;
            endcase
        end
    end

    assign bus.irq = tcon.ie && tcon.flag;

endmodule

// File: tb/tb_timer_unit.sv
// Self-checking bench for timer_unit: directed scenarios plus random bus traffic scored
// against a register-level behavioural model.
module tb_timer_unit;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_PSC  = 32'h4000_000C;
    localparam logic [31:0] A_BAD  = 32'h4000_0010;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    timer_if bus();

    timer_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model state, one variable per architectural register field.
    logic [31:0] m_th, m_tl;
    logic        m_en, m_ie, m_flag, m_os;
    logic [15:0] m_psc, m_pcnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_th = '0; m_tl = '0; m_en = 0; m_ie = 0; m_flag = 0; m_os = 0;
        m_psc = '0; m_pcnt = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        case (a)
            A_TH:   return m_th;
            A_TL:   return m_tl;
            A_TCON: return {28'd0, m_os, m_flag, m_ie, m_en};
`ifdef TIMER_PRESCALE_EN
            A_PSC:  return {16'd0, m_psc};
`endif
            default: return 32'h0;
        endcase
    endfunction

    // One clock of the timer: count first with the old register values, then apply the write.
    task automatic model_cycle(input logic wr, input logic [31:0] a, input logic [31:0] d);
        logic tick, ovf;
`ifdef TIMER_PRESCALE_EN
        logic psc_wr;
        psc_wr = wr && (a == A_PSC);
        tick   = m_en && !psc_wr && (m_pcnt == m_psc);
        m_pcnt = (!m_en || psc_wr || tick) ? 16'd0 : m_pcnt + 16'd1;
`else
        tick = m_en;
`endif
        ovf = tick && (m_tl == 32'hFFFF_FFFF);
        if (tick) m_tl = ovf ? m_th : m_tl + 32'd1;
        if (ovf) begin
            m_flag = 1'b1;
            if (m_os) m_en = 1'b0;
        end
        if (wr) begin
            case (a)
                A_TH: m_th = d;
                A_TL: m_tl = d;
                A_TCON: begin
                    m_en = d[0];
                    m_ie = d[1];
                    m_os = d[3];
                    if (d[2] && !ovf) m_flag = 1'b0;
                end
`ifdef TIMER_PRESCALE_EN
                A_PSC: m_psc = d[15:0];
`endif
                default: ;
            endcase
        end
    endtask

    // One bus cycle: combinational read (pre-write value) checked before the edge, irq after it.
    task automatic bus_cycle(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        bus.rd = rd; bus.wr = wr; bus.addr = a; bus.wdata = d;
        #1;
        if (rd) check("rdata", bus.rdata, model_read(a));
        @(posedge clk);
        model_cycle(wr, a, d);
        #1;
        bus.rd = 0; bus.wr = 0;
        check("irq", {31'd0, bus.irq}, {31'd0, m_ie & m_flag});
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d);
        bus_cycle(1'b0, 1'b1, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, A_TH, 32'h0);
    endtask

    // Combinational read inside the current cycle, against a value the scenario states outright.
    task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string tag);
        bus.rd = 1; bus.wr = 0; bus.addr = a;
        #1;
        check(tag, bus.rdata, exp);
        bus.rd = 0;
    endtask

    logic [31:0] rand_addrs [7] = '{A_TH, A_TL, A_TCON, A_PSC, A_TH + 32'h1, A_BAD, 32'h0000_0008};

    initial begin
        bus.rd = 0; bus.wr = 0; bus.addr = '0; bus.wdata = '0;
        reset = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1;

        // Reset state
        check("reset_irq", {31'd0, bus.irq}, 32'd0);
        peek(A_TH, 32'h0, "reset_th");
        peek(A_TL, 32'h0, "reset_tl");
        peek(A_TCON, 32'h0, "reset_tcon");

        // Reset mid-count with an interrupt pending
        write(A_TH, 32'h0000_0123);
        write(A_TL, 32'hFFFF_FFFD);
        write(A_TCON, 32'h3);
        idle(4);
        check("pre_reset_irq", {31'd0, bus.irq}, 32'd1);
        reset = 0;
        model_reset();
        #1 check("async_reset_irq", {31'd0, bus.irq}, 32'd0);
        peek(A_TH, 32'h0, "rst_th");
        peek(A_TL, 32'h0, "rst_tl");
        peek(A_TCON, 32'h0, "rst_tcon");
        reset = 1;
        @(posedge clk); #1;
        peek(A_TL, 32'h0, "rst_tl_held");

        // Auto-reload: overflow two ticks after EN, then every 16 ticks
        write(A_TH, 32'hFFFF_FFF0);
        write(A_TL, 32'hFFFF_FFFE);
        write(A_TCON, 32'h3);
        idle(2);
        peek(A_TL, 32'hFFFF_FFF0, "reload_tl");
        peek(A_TCON, 32'h7, "reload_tcon");
        check("reload_irq", {31'd0, bus.irq}, 32'd1);
        idle(15);
        peek(A_TL, 32'hFFFF_FFFF, "second_pre_ovf_tl");
        idle(1);
        peek(A_TL, 32'hFFFF_FFF0, "second_reload_tl");

        // Write-1-clear coinciding with an overflow, then in a quiet cycle
        idle(15);
        write(A_TCON, 32'h7);
        peek(A_TCON, 32'h7, "w1c_race_tcon");
        check("w1c_race_irq", {31'd0, bus.irq}, 32'd1);
        write(A_TCON, 32'h7);
        peek(A_TCON, 32'h3, "w1c_quiet_tcon");
        check("w1c_quiet_irq", {31'd0, bus.irq}, 32'd0);

        // One-shot: EN drops on overflow, IE/IF set, TL frozen after the reload
        write(A_TCON, 32'h0);
        write(A_TH, 32'h0);
        write(A_TL, 32'hFFFF_FFFF);
        write(A_TCON, 32'hB);
        idle(1);
        peek(A_TL, 32'h0, "oneshot_tl");
        bus.rd = 1; bus.addr = A_TCON;
        #1 check("oneshot_tcon_low", bus.rdata & 32'h7, 32'h6);
        bus.rd = 0;
        peek(A_TCON, 32'hE, "oneshot_tcon");
        idle(10);
        peek(A_TL, 32'h0, "oneshot_frozen_tl");
        write(A_TL, 32'h0000_0042);
        peek(A_TL, 32'h0000_0042, "stopped_tl_writable");

        // Decode: unmapped reads/writes, rd low, misaligned address
        peek(A_BAD, 32'h0, "unmapped_read");
        write(A_BAD, 32'hFFFF_FFFF);
        peek(A_TH, 32'h0, "unmapped_write_th");
        peek(A_TL, 32'h0000_0042, "unmapped_write_tl");
        peek(A_TCON, 32'hE, "unmapped_write_tcon");
        bus.rd = 0; bus.addr = A_TL;
        #1 check("rd_low_rdata", bus.rdata, 32'h0);
        peek(A_TH + 32'h1, 32'h0, "misaligned_read");
`ifndef TIMER_PRESCALE_EN
        write(A_PSC, 32'h0000_0003);
        peek(A_PSC, 32'h0, "no_psc_read");
`endif

        // TH write at the overflow edge reloads the old TH; rd+wr shows the pre-write value
        write(A_TCON, 32'h4);
        write(A_TH, 32'h0000_0100);
        write(A_TL, 32'hFFFF_FFFE);
        write(A_TCON, 32'h1);
        idle(1);
        write(A_TH, 32'h0000_0200);
        peek(A_TL, 32'h0000_0100, "th_race_old_reload");
        peek(A_TH, 32'h0000_0200, "th_race_new_th");
        bus_cycle(1'b1, 1'b1, A_TH, 32'h0000_0300);
        peek(A_TH, 32'h0000_0300, "rdwr_th_after");

`ifdef TIMER_PRESCALE_EN
        // Prescaler: PSC=3 gives one tick every 4 cycles; a PSC write restarts the period
        write(A_TCON, 32'h0);
        write(A_PSC, 32'h3);
        write(A_TL, 32'h0);
        write(A_TCON, 32'h1);
        idle(3);
        peek(A_TL, 32'h0, "psc_tl_3");
        idle(1);
        peek(A_TL, 32'h1, "psc_tl_4");
        idle(4);
        peek(A_TL, 32'h2, "psc_tl_8");
        idle(2);
        write(A_PSC, 32'h3);
        idle(3);
        peek(A_TL, 32'h2, "psc_restart_hold");
        idle(1);
        peek(A_TL, 32'h3, "psc_restart_tick");
`endif

        // Random traffic against the model, biased towards overflow and counting
        write(A_TCON, 32'h7);
        for (int i = 0; i < 400; i++) begin
            int unsigned k, idx;
            logic [31:0] a, d;
            k   = $urandom_range(0, 9);
            idx = $urandom_range(0, 6);
            a   = rand_addrs[idx];
            d   = $urandom;
            if (idx == 1) d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            if (idx == 2 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
            if (idx == 3) d = 32'($urandom_range(0, 3));
            bus_cycle(k inside {2, 3, 4}, k inside {4, 5, 6}, a, d);
        end
        peek(A_TH, model_read(A_TH), "final_th");
        peek(A_TL, model_read(A_TL), "final_tl");
        peek(A_TCON, model_read(A_TCON), "final_tcon");
        peek(A_PSC, model_read(A_PSC), "final_psc");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench did not complete");
    end

endmodule
